// File: rtl/sble_config_loader.sv
// sble_config_loader: serial configuration loader for a bank of SBLE input
// multiplexers. Bits are shifted MSB-first into a shadow register, every
// selector field is range-checked, and a good frame is committed atomically
// to config_out. A bad frame leaves the previous configuration in place.
//
// Optional feature macro: SBLE_CFG_PARITY_EN
//   defined   -> one even-parity bit follows the payload (PARITY state)
//   undefined -> frame is exactly CFG_BITS bits, no parity check

// Range check for one selector field.
module sble_sel_check #(
    parameter int SEL_WIDTH = 6,
    parameter int MAX_SEL   = 43
) (
    input  logic [SEL_WIDTH-1:0] sel,
    output logic                 bad
);
    localparam logic [SEL_WIDTH-1:0] MAX_V = MAX_SEL[SEL_WIDTH-1:0];

    assign bad = (sel > MAX_V);
endmodule

module sble_config_loader #(
    parameter int NUM_MUX   = 4,
    parameter int SEL_WIDTH = 6,
    parameter int MAX_SEL   = 43
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_start,
    input  logic                            cfg_bit,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    output logic [NUM_MUX*SEL_WIDTH-1:0]    config_out,
    output logic                            cfg_done,
    output logic                            cfg_error
);
    localparam int CFG_BITS = NUM_MUX * SEL_WIDTH;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CHECK  = 2'd2
`ifdef SBLE_CFG_PARITY_EN
        ,
        ST_PARITY = 2'd3
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CFG_BITS-1:0]   shadow_q, shadow_d;
    logic [CFG_BITS-1:0]   config_q, config_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [NUM_MUX-1:0]    field_bad;
    logic                  frame_bad;

`ifdef SBLE_CFG_PARITY_EN
    logic                  par_q, par_d;
    logic                  par_bad;

    // Even parity over payload plus the trailing parity bit.
    assign par_bad = (^shadow_q) ^ par_q;
`endif

    // One range checker per mux field of the shadow register.
    for (genvar i = 0; i < NUM_MUX; i++) begin : g_chk
        sble_sel_check #(
            .SEL_WIDTH (SEL_WIDTH),
            .MAX_SEL   (MAX_SEL)
        ) u_chk (
            .sel (shadow_q[i*SEL_WIDTH +: SEL_WIDTH]),
            .bad (field_bad[i])
        );
    end

`ifdef SBLE_CFG_PARITY_EN
    assign frame_bad = (|field_bad) | par_bad;
`else
    assign frame_bad = |field_bad;
`endif

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        config_d  = config_q;
        done_d    = done_q;
        error_d   = error_q;
        cfg_ready = 1'b0;
`ifdef SBLE_CFG_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    // Restart: a bit offered alongside the start is dropped.
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else if (cfg_valid) begin
                    // Shifting left puts the first accepted bit at the MSB.
                    shadow_d = {shadow_q[CFG_BITS-2:0], cfg_bit};
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
`ifdef SBLE_CFG_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_CHECK;
`endif
                    end
                end
            end
`ifdef SBLE_CFG_PARITY_EN
            ST_PARITY: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else if (cfg_valid) begin
                    par_d   = cfg_bit;
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_CHECK: begin
                // cfg_start is deliberately ignored here; the commit completes.
                if (frame_bad) begin
                    error_d = 1'b1;
                end else begin
                    config_d = shadow_q;
                    done_d   = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset also clears the committed config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            config_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            config_q <= config_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

`ifdef SBLE_CFG_PARITY_EN
    // Captured parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif

    assign config_out = config_q;
    assign cfg_done   = done_q;
    assign cfg_error  = error_q;
endmodule

// File: tb/tb_sble_config_loader.sv
// Testbench for sble_config_loader (NUM_MUX=2, SEL_WIDTH=6, MAX_SEL=43).
// Honours SBLE_CFG_PARITY_EN by appending an even-parity bit to each frame.
module tb_sble_config_loader;
    localparam int NM = 2;
    localparam int SW = 6;
    localparam int MX = 43;
    localparam int CB = NM * SW;
`ifdef SBLE_CFG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CB-1:0] config_out;
    logic          cfg_done;
    logic          cfg_error;

    int n_chk = 0;
    int n_fail = 0;
    logic [CB-1:0] model_cfg = '0;

    sble_config_loader #(.NUM_MUX(NM), .SEL_WIDTH(SW), .MAX_SEL(MX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .config_out (config_out),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Frame acceptance rule straight from the field/parity definition.
    function automatic bit model_ok(input logic [CB-1:0] f, input logic pbit);
        for (int i = 0; i < NM; i++)
            if (((int'(f) >> (SW * i)) & ((1 << SW) - 1)) > MX) return 1'b0;
        if (PAR && ((^f) ^ pbit)) return 1'b0;
        return 1'b1;
    endfunction

    // Sends one frame (optionally with a gap and a start pulse during CHECK)
    // and checks ready, exact commit latency and final outputs.
    task automatic send_frame(input logic [CB-1:0] f, input logic pbit,
                              input int gap_pos, input int gaps, input bit start_in_check,
                              input logic [CB-1:0] exp_cfg, input logic ok, input string nm);
        logic rdy_bad;
        rdy_bad = 1'b0;
        @(negedge clk);
        cfg_start = 1'b1; cfg_valid = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        chk({nm, " cleared"}, {30'b0, cfg_done, cfg_error}, 32'd0);
        for (int i = 0; i < CB + int'(PAR); i++) begin
            if (i == gap_pos) begin
                for (int g = 0; g < gaps; g++) begin
                    cfg_valid = 1'b0;
                    if (cfg_ready !== 1'b1) rdy_bad = 1'b1;
                    @(negedge clk);
                end
            end
            cfg_valid = 1'b1;
            cfg_bit   = (i < CB) ? f[CB-1-i] : pbit;
            if (cfg_ready !== 1'b1) rdy_bad = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        chk({nm, " ready"}, {31'b0, rdy_bad}, 32'd0);
        // Last bit taken one edge ago: nothing committed yet, not ready.
        chk({nm, " pre-commit"}, {29'b0, cfg_ready, cfg_done, cfg_error}, 32'd0);
        if (start_in_check) cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk({nm, " done"},   {31'b0, cfg_done},  {31'b0, ok});
        chk({nm, " error"},  {31'b0, cfg_error}, {31'b0, !ok});
        chk({nm, " config"}, {20'b0, config_out}, {20'b0, exp_cfg});
        chk({nm, " idle ready"}, {31'b0, cfg_ready}, 32'd0);
    endtask

    typedef struct {
        logic [CB-1:0] f;
        logic          ok;
        logic [CB-1:0] cfg;
    } vec_t;

    initial begin
        vec_t vt[6];
        logic [CB-1:0] f;
        logic pb;
        bit ok;
        int gp;

        vt[0] = '{12'h16B, 1'b1, 12'h16B};  // mux1=5, mux0=43
        vt[1] = '{12'hB00, 1'b0, 12'h16B};  // mux1=44 rejected
        vt[2] = '{12'h001, 1'b1, 12'h001};
        vt[3] = '{12'hFFF, 1'b0, 12'h001};  // both 63
        vt[4] = '{12'hAEB, 1'b1, 12'hAEB};  // both exactly 43
        vt[5] = '{12'hAEC, 1'b0, 12'hAEB};  // mux0=44

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset config", {20'b0, config_out}, 32'd0);
        chk("reset flags", {29'b0, cfg_ready, cfg_done, cfg_error}, 32'd0);
        rst_n = 1'b1;

        // Table-driven frames, contiguous
        for (int i = 0; i < 6; i++)
            send_frame(vt[i].f, ^vt[i].f, -1, 0, 1'b0, vt[i].cfg, vt[i].ok, $sformatf("vec%0d", i));

        // Same good frame with a 3-cycle valid gap mid-stream
        send_frame(12'h16B, ^12'h16B, 6, 3, 1'b0, 12'h16B, 1'b1, "gap");

        // IDLE ignores cfg_valid
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        chk("idle ignore", {19'b0, config_out, cfg_done}, {19'b0, 12'h16B, 1'b1});

        // Restart after 7 bits; bit offered with the start is discarded
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            @(negedge clk);
        end
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; cfg_valid = 1'b0;
        chk("restart ready", {31'b0, cfg_ready}, 32'd1);
        chk("restart config held", {20'b0, config_out}, 32'h16B);
        for (int i = 0; i < CB + int'(PAR); i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = (i < CB) ? ((i == CB - 1) ? 1'b1 : 1'b0) : 1'b1;  // 0x001, parity 1
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        chk("restart pre-commit", {30'b0, cfg_done, cfg_error}, 32'd0);
        @(negedge clk);
        chk("restart commit", {19'b0, config_out, cfg_done}, {19'b0, 12'h001, 1'b1});
        model_cfg = 12'h001;

        // cfg_start during CHECK is ignored; commit completes, stays IDLE
        send_frame(12'h2A5, ^12'h2A5, -1, 0, 1'b1, 12'h2A5, 1'b1, "start_in_check");
        @(negedge clk);
        chk("start_in_check idle", {30'b0, cfg_ready, cfg_done}, 32'd1);
        model_cfg = 12'h2A5;

`ifdef SBLE_CFG_PARITY_EN
        // Wrong parity bit rejects an otherwise good frame
        send_frame(12'h16B, ~(^12'h16B), -1, 0, 1'b0, 12'h2A5, 1'b0, "bad parity");
`endif

        // Randomized frames against the model
        for (int n = 0; n < 24; n++) begin
            f = CB'($urandom);
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < NM; i++)
                    f[i*SW +: SW] = SW'(int'(f[i*SW +: SW]) % (MX + 1));
            pb = ^f;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            ok = model_ok(f, pb);
            if (ok) model_cfg = f;
            gp = $urandom_range(0, CB);
            send_frame(f, pb, gp, $urandom_range(0, 3), 1'b0, model_cfg, ok, $sformatf("rand%0d", n));
        end

        // Asynchronous reset mid-frame after a prior commit
        send_frame(12'h16B, ^12'h16B, -1, 0, 1'b0, 12'h16B, 1'b1, "pre-reset");
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset config", {20'b0, config_out}, 32'd0);
        chk("async reset flags", {29'b0, cfg_ready, cfg_done, cfg_error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(12'hAEB, ^12'hAEB, -1, 0, 1'b0, 12'hAEB, 1'b1, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
